// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory responder: multi-cycle RAM with byte/half/word access and load extension.
// Holds stall high until the access completes; faulting requests are rejected without touching RAM.
module mem_stage_dmem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        accessFault
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        mem [2**ADDR_W];

    logic               req, fault, illegal_f3, misaligned, do_access;
    logic [ADDR_W-1:0]  widx;
    logic [31:0]        rd_word, rd_shift, load_val, wr_lanes;
    logic [3:0]         wr_be;
    logic               unused_addr_hi;

    assign req            = memRead | memWrite;
    assign widx           = address[ADDR_W+1:2];
    assign unused_addr_hi = ^address[31:ADDR_W+2];

    always_comb begin
        illegal_f3 = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
            3'b100, 3'b101:         illegal_f3 = memWrite;
            default:                illegal_f3 = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                     ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        fault      = (memRead & memWrite) | illegal_f3 | misaligned;
    end

    assign accessFault = req & fault;
    assign stall       = req & ~fault & (state_q != ST_DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !fault) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_BUSY: begin
                // Dropping the request mid-access is a pipeline flush: abandon without touching RAM.
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    do_access = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word  = mem[widx];
        rd_shift = rd_word >> {address[1:0], 3'b000};
        case (funct3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {24'h0, rd_shift[7:0]};
            3'b101:  load_val = {16'h0, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
        rdata_d = (do_access && memRead) ? load_val : rdata_q;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                wr_lanes = {4{writeData[7:0]}};
                wr_be    = 4'b0001 << address[1:0];
            end
            2'b01: begin
                wr_lanes = {2{writeData[15:0]}};
                wr_be    = address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_lanes = writeData;
                wr_be    = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents survive reset; only the byte lanes selected by the access are written.
    always_ff @(posedge clock) begin
        if (do_access && memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[widx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign readData = rdata_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed and randomized bench for mem_stage_dmem_ctrl against a word-array reference model.
module tb_mem_stage_dmem_ctrl;

    localparam int ADDR_W = 10;
    localparam int WAITC  = 2;
    localparam int DEPTH  = 2**ADDR_W;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        stall, accessFault;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd;

    mem_stage_dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .address(address), .writeData(writeData),
        .readData(readData), .stall(stall), .accessFault(accessFault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        int sz;
        if (rd && wr) return 1'b1;
        if (wr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1'b1;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, bv, hv;
        int off;
        w   = ref_mem[(a / 4) % DEPTH];
        off = a % 4;
        bv  = (w >> (8 * off)) & 32'hFF;
        hv  = (w >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 128) ? bv - 32'd256 : bv;
            3'd1:    return (hv >= 32768) ? hv - 32'd65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int off;
        int idx;
        idx  = (a / 4) % DEPTH;
        off  = a % 4;
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
    endtask

    // Called just after a rising edge; returns just after the rising edge that ends the request.
    task automatic run_req(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input string tag);
        int n;
        memRead = rd; memWrite = wr; funct3 = f3; address = a; writeData = d;
        @(negedge clock);
        if (!rd && !wr) begin
            chk({tag, "_idle_stall"}, {31'h0, stall}, 32'h0);
            chk({tag, "_idle_fault"}, {31'h0, accessFault}, 32'h0);
        end else if (model_fault(rd, wr, f3, a)) begin
            chk({tag, "_fault"}, {31'h0, accessFault}, 32'h1);
            chk({tag, "_fault_stall"}, {31'h0, stall}, 32'h0);
            chk({tag, "_fault_rdata"}, readData, exp_rd);
        end else begin
            chk({tag, "_nofault"}, {31'h0, accessFault}, 32'h0);
            n = 0;
            while (stall === 1'b1 && n < 50) begin
                n++;
                @(negedge clock);
            end
            chk({tag, "_stall_cycles"}, 32'(n), 32'(WAITC + 2));
            if (rd) exp_rd = model_load(f3, a);
            if (wr) model_store(f3, a, d);
            chk({tag, "_rdata"}, readData, exp_rd);
        end
        @(posedge clock); #1;
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        funct3 = 3'd0; address = '0; writeData = '0; exp_rd = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        #12;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_fault", {31'h0, accessFault}, 32'h0);
        chk("rst_rdata", readData, 32'h0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        run_req(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        run_req(1, 0, 3'd2, 32'h10, 32'h0, "lw10");
        chk("lw10_const", readData, 32'hDEADBEEF);
        run_req(0, 1, 3'd0, 32'h13, 32'h0000_0080, "sb13");
        run_req(1, 0, 3'd0, 32'h13, 32'h0, "lb13");
        chk("lb13_const", readData, 32'hFFFF_FF80);
        run_req(1, 0, 3'd4, 32'h13, 32'h0, "lbu13");
        chk("lbu13_const", readData, 32'h0000_0080);
        run_req(1, 0, 3'd2, 32'h10, 32'h0, "lw10b");
        chk("lw10b_const", readData, 32'h80AD_BEEF);
        run_req(1, 0, 3'd1, 32'h11, 32'h0, "lh11");
        run_req(0, 1, 3'd2, 32'h12, 32'h5555_5555, "sw12");
        run_req(1, 0, 3'd2, 32'h10, 32'h0, "lw10c");
        chk("lw10c_const", readData, 32'h80AD_BEEF);
        run_req(1, 0, 3'd5, 32'h12, 32'h0, "lhu12");
        run_req(1, 0, 3'd1, 32'h12, 32'h0, "lh12");
        run_req(0, 1, 3'd4, 32'h10, 32'h0, "sbu_illegal");

        // Flush: request withdrawn in the second BUSY cycle must abandon the store.
        run_req(0, 1, 3'd2, 32'h20, 32'h1111_1111, "sw20");
        memWrite = 1'b1; funct3 = 3'd2; address = 32'h20; writeData = 32'h2222_2222;
        @(negedge clock);
        chk("flush_stall_n", {31'h0, stall}, 32'h1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        memWrite = 1'b0;
        @(negedge clock);
        chk("flush_stall_drop", {31'h0, stall}, 32'h0);
        @(posedge clock); #1;
        run_req(1, 0, 3'd2, 32'h20, 32'h0, "lw20_flush");
        chk("lw20_flush_const", readData, 32'h1111_1111);

        // Reset mid-BUSY clears readData at once and discards the store.
        memWrite = 1'b1; funct3 = 3'd2; address = 32'h20; writeData = 32'h3333_3333;
        @(negedge clock);
        @(negedge clock);
        memWrite = 1'b0; reset_n = 1'b0;
        #1;
        chk("rstmid_stall", {31'h0, stall}, 32'h0);
        chk("rstmid_rdata", readData, 32'h0);
        exp_rd = '0;
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        run_req(1, 0, 3'd2, 32'h20, 32'h0, "lw20_rst");
        chk("lw20_rst_const", readData, 32'h1111_1111);

        run_req(0, 1, 3'd2, 32'h1000, 32'h1234_5678, "sw_wrap");
        run_req(1, 0, 3'd2, 32'h0000, 32'h0, "lw_wrap");
        chk("lw_wrap_const", readData, 32'h1234_5678);

        for (int i = 0; i < 16; i++)
            run_req(0, 1, 3'd2, 32'(i * 4), $urandom, "rinit");
        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            run_req(sel == 1 || (sel >= 2 && sel <= 5), sel == 1 || sel >= 6,
                    3'($urandom_range(0, 7)), a, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
